// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: arbitrates one host port and a per-bank compute engine over
// NUM_BANKS single-port SRAM banks. The host has a one-entry holding register.
// The engine keeps priority on the held bank until the host has waited
// STARVE_LIMIT contended cycles. Host reads return data two cycles after the win.
// Optional macro ARB_HOST_PRIORITY_EN: the host always wins the cycle after capture,
// and the wait counter is removed.

// Per-bank SRAM drive register: host winner first, then engine, else idle.
module sram_bank_port #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_sel,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              eng_en,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din
);
    // Register the bank controls; addr/din keep their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (host_sel) begin
            mem_ce   <= 1'b1;
            mem_we   <= host_we;
            mem_addr <= host_addr;
            mem_din  <= host_wdata;
        end else if (eng_en) begin
            mem_ce   <= 1'b1;
            mem_we   <= eng_we;
            mem_addr <= eng_addr;
            mem_din  <= eng_wdata;
        end else begin
            mem_ce   <= 1'b0;
            mem_we   <= 1'b0;
        end
    end
endmodule

module sram_bank_arbiter #(
    parameter int NUM_BANKS    = 3,
    parameter int BANK_W       = 2,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_req_valid,
    output logic                        host_req_ready,
    input  logic                        host_req_we,
    input  logic [BANK_W-1:0]           host_req_bank,
    input  logic [ADDR_W-1:0]           host_req_addr,
    input  logic [DATA_W-1:0]           host_req_wdata,
    output logic                        host_rsp_valid,
    output logic [DATA_W-1:0]           host_rsp_rdata,
    output logic                        err_bad_bank,
    input  logic [NUM_BANKS-1:0]        eng_en,
    input  logic [NUM_BANKS-1:0]        eng_we,
    input  logic [NUM_BANKS*ADDR_W-1:0] eng_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] eng_wdata,
    output logic [NUM_BANKS-1:0]        eng_grant,
    output logic [NUM_BANKS*DATA_W-1:0] eng_rdata,
    output logic [NUM_BANKS-1:0]        mem_ce,
    output logic [NUM_BANKS-1:0]        mem_we,
    output logic [NUM_BANKS*ADDR_W-1:0] mem_addr,
    output logic [NUM_BANKS*DATA_W-1:0] mem_din,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_dout
);
    // vld_pipe[0]: read launched to the SRAM, vld_pipe[1]: response register.
    localparam int RD_STAGES = 1;

    logic                 hold_valid;
    logic                 hold_we;
    logic [BANK_W-1:0]    hold_bank;
    logic [ADDR_W-1:0]    hold_addr;
    logic [DATA_W-1:0]    hold_wdata;
    logic                 hold_bad;
    logic                 eng_en_held;
    logic                 host_win;
    logic [NUM_BANKS-1:0] host_sel;
    logic [RD_STAGES:0]   vld_pipe;
    logic [BANK_W-1:0]    rd_bank;
    logic                 rd_bad;
    logic [DATA_W-1:0]    rd_dout;

    assign host_req_ready = ~hold_valid;
    assign hold_bad       = (int'(hold_bank) >= NUM_BANKS);
    assign host_rsp_valid = vld_pipe[RD_STAGES];
    assign eng_rdata      = mem_dout;

    // Engine request on the held bank; an out-of-range bank sees no engine.
    always_comb begin
        eng_en_held = 1'b0;
        for (int k = 0; k < NUM_BANKS; k++)
            if (int'(hold_bank) == k) eng_en_held = eng_en[k];
    end

`ifdef ARB_HOST_PRIORITY_EN
    assign host_win = hold_valid;
`else
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // A bad bank has eng_en_held=0, so it wins on its first arbitrated cycle.
    assign host_win = hold_valid & (~eng_en_held | (wait_cnt == WAIT_W'(STARVE_LIMIT)));

    // Count contended cycles of the held request, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (host_win)
            wait_cnt <= '0;
        else if (hold_valid && wait_cnt != WAIT_W'(STARVE_LIMIT))
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end
`endif

    // Steal only the held bank on a host win; all other banks pass through.
    always_comb begin
        host_sel = '0;
        for (int k = 0; k < NUM_BANKS; k++)
            host_sel[k] = host_win & (int'(hold_bank) == k);
        eng_grant = eng_en & ~host_sel;
    end

    // Select the read bank's SRAM output for the response register.
    always_comb begin
        rd_dout = '0;
        for (int k = 0; k < NUM_BANKS; k++)
            if (int'(rd_bank) == k) rd_dout = mem_dout[k*DATA_W +: DATA_W];
    end

    // One-entry holding register; it is empty again the cycle after a win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_we    <= 1'b0;
            hold_bank  <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (host_req_valid && host_req_ready) begin
            hold_valid <= 1'b1;
            hold_we    <= host_req_we;
            hold_bank  <= host_req_bank;
            hold_addr  <= host_req_addr;
            hold_wdata <= host_req_wdata;
        end else if (host_win) begin
            hold_valid <= 1'b0;
        end
    end

    // Sticky flag for a host request to a non-existent bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_bad_bank <= 1'b0;
        else if (host_win && hold_bad)
            err_bad_bank <= 1'b1;
    end

    // Read pipeline: launch on win, capture mem_dout one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe       <= '0;
            rd_bank        <= '0;
            rd_bad         <= 1'b0;
            host_rsp_rdata <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_STAGES-1:0], host_win & ~hold_we};
            if (host_win && !hold_we) begin
                rd_bank <= hold_bank;
                rd_bad  <= hold_bad;
            end
            if (vld_pipe[0])
                host_rsp_rdata <= rd_bad ? '0 : rd_dout;
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        sram_bank_port #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .host_sel   (host_sel[k]),
            .host_we    (hold_we),
            .host_addr  (hold_addr),
            .host_wdata (hold_wdata),
            .eng_en     (eng_en[k]),
            .eng_we     (eng_we[k]),
            .eng_addr   (eng_addr[k*ADDR_W +: ADDR_W]),
            .eng_wdata  (eng_wdata[k*DATA_W +: DATA_W]),
            .mem_ce     (mem_ce[k]),
            .mem_we     (mem_we[k]),
            .mem_addr   (mem_addr[k*ADDR_W +: ADDR_W]),
            .mem_din    (mem_din[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a behavioural model of the arbitration rules,
// the bank contents and the read-response timing.
module tb_sram_bank_arbiter;
    localparam int NB = 3, BW = 2, AW = 10, DW = 8, SL = 4;
`ifdef ARB_HOST_PRIORITY_EN
    localparam int LIM = 0;
`else
    localparam int LIM = SL;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              host_req_valid = 1'b0, host_req_ready, host_req_we = 1'b0;
    logic [BW-1:0]     host_req_bank = '0;
    logic [AW-1:0]     host_req_addr = '0;
    logic [DW-1:0]     host_req_wdata = '0;
    logic              host_rsp_valid, err_bad_bank;
    logic [DW-1:0]     host_rsp_rdata;
    logic [NB-1:0]     eng_en = '0, eng_we = '0, eng_grant, mem_ce, mem_we;
    logic [NB*AW-1:0]  eng_addr = '0, mem_addr;
    logic [NB*DW-1:0]  eng_wdata = '0, eng_rdata, mem_din, mem_dout;

    sram_bank_arbiter #(.NUM_BANKS(NB), .BANK_W(BW), .ADDR_W(AW), .DATA_W(DW),
                        .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_bank(host_req_bank),
        .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
        .err_bad_bank(err_bad_bank),
        .eng_en(eng_en), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_grant(eng_grant), .eng_rdata(eng_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // SRAM banks: write on the edge, read data follows the registered address.
    logic [DW-1:0] sram [NB][1<<AW];
    logic          pl_we = 1'b0;
    int            pl_bank = 0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) sram[pl_bank][pl_addr] <= pl_data;
        for (int k = 0; k < NB; k++)
            if (mem_ce[k] && mem_we[k]) sram[k][mem_addr[k*AW +: AW]] <= mem_din[k*DW +: DW];
    end
    for (genvar k = 0; k < NB; k++) begin : g_sram
        assign mem_dout[k*DW +: DW] = sram[k][mem_addr[k*AW +: AW]];
    end

    // Reference model state.
    typedef struct { bit we; logic [BW-1:0] bank; logic [AW-1:0] addr; logic [DW-1:0] wdata; } hreq_t;
    typedef struct { int at; logic [DW-1:0] data; } rsp_t;
    logic [DW-1:0] refmem [NB][1<<AW];
    hreq_t hq[$];
    hreq_t hcur;
    bit    hv_active;
    rsp_t  rsp_q[$];
    bit    m_pend, m_we, m_err;
    int    m_bank, m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit [NB-1:0]   exp_ce, exp_we, erd_vld, e_en, e_we, e_granted, e_force;
    bit            exp_regs_vld;
    logic [AW-1:0] exp_addr [NB];
    logic [DW-1:0] exp_din [NB];
    logic [DW-1:0] erd_val [NB];
    logic [AW-1:0] e_addr [NB];
    logic [DW-1:0] e_wd [NB];
    int p_eng = 0, p_wr = 50;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] addr_at(input int i);
        return (i < 8) ? AW'(i) : {AW{1'b1}};
    endfunction

    function automatic logic [AW-1:0] raddr();
        return addr_at($urandom_range(0, 8));
    endfunction

    task automatic model_reset();
        m_pend = 0; m_wait = 0; m_err = 0;
        rsp_q.delete(); hq.delete(); hv_active = 0;
        exp_ce = '0; exp_we = '0; exp_regs_vld = 1; erd_vld = '0;
        e_en = '0; e_we = '0; e_granted = '0;
        host_req_valid = 0; eng_en = '0; eng_we = '0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational outputs, then advance the model.
    task automatic step();
        bit win, cap;
        bit [NB-1:0] hsel, gexp;
        @(negedge clk);
        if (rsp_q.size() > 0 && rsp_q[0].at == cyc) begin
            check("rsp_valid", host_rsp_valid, 1);
            check("rsp_rdata", host_rsp_rdata, rsp_q[0].data);
            void'(rsp_q.pop_front());
        end else begin
            check("rsp_idle", host_rsp_valid, 0);
        end
        check("err_bad_bank", err_bad_bank, m_err);
        if (exp_regs_vld) begin
            check("mem_ce", mem_ce, exp_ce);
            check("mem_we", mem_we, exp_we);
            for (int k = 0; k < NB; k++) begin
                if (exp_ce[k]) check("mem_addr", mem_addr[k*AW +: AW], exp_addr[k]);
                if (exp_we[k]) check("mem_din", mem_din[k*DW +: DW], exp_din[k]);
            end
        end
        for (int k = 0; k < NB; k++)
            if (erd_vld[k]) check("eng_rdata", eng_rdata[k*DW +: DW], erd_val[k]);

        if (!hv_active && hq.size() > 0) begin
            hcur = hq.pop_front();
            hv_active = 1;
        end
        host_req_valid = hv_active;
        host_req_we    = hcur.we;
        host_req_bank  = hcur.bank;
        host_req_addr  = hcur.addr;
        host_req_wdata = hcur.wdata;
        for (int k = 0; k < NB; k++) begin
            if (!(e_en[k] && !e_granted[k])) begin
                e_en[k]   = e_force[k] || ($urandom_range(0, 99) < p_eng);
                e_we[k]   = ($urandom_range(0, 99) < p_wr);
                e_addr[k] = raddr();
                e_wd[k]   = DW'($urandom);
            end
            eng_addr[k*AW +: AW]  = e_addr[k];
            eng_wdata[k*DW +: DW] = e_wd[k];
        end
        eng_en = e_en;
        eng_we = e_we;
        #1;

        win  = m_pend && (m_bank >= NB || !e_en[m_bank] || m_wait >= LIM);
        hsel = '0;
        if (win && m_bank < NB) hsel[m_bank] = 1'b1;
        gexp = e_en & ~hsel;
        check("eng_grant", eng_grant, gexp);
        check("req_ready", host_req_ready, !m_pend);

        cap = hv_active && !m_pend;
        erd_vld = '0;
        exp_regs_vld = 1;
        for (int k = 0; k < NB; k++) begin
            if (hsel[k]) begin
                exp_ce[k] = 1; exp_we[k] = m_we; exp_addr[k] = m_addr; exp_din[k] = m_wdata;
            end else if (e_en[k]) begin
                exp_ce[k] = 1; exp_we[k] = e_we[k]; exp_addr[k] = e_addr[k]; exp_din[k] = e_wd[k];
                if (!e_we[k]) begin
                    erd_vld[k] = 1;
                    erd_val[k] = refmem[k][e_addr[k]];
                end
            end else begin
                exp_ce[k] = 0; exp_we[k] = 0;
            end
        end
        if (win) begin
            if (!m_we)
                rsp_q.push_back('{cyc + 2, (m_bank < NB) ? refmem[m_bank][m_addr] : DW'(0)});
            else if (m_bank < NB)
                refmem[m_bank][m_addr] = m_wdata;
            if (m_bank >= NB) m_err = 1;
            m_pend = 0;
            m_wait = 0;
        end else if (m_pend) begin
            m_wait++;
        end
        for (int k = 0; k < NB; k++)
            if (e_en[k] && !hsel[k] && e_we[k]) refmem[k][e_addr[k]] = e_wd[k];
        e_granted = gexp;
        if (cap) begin
            m_pend = 1; m_we = hcur.we; m_bank = int'(hcur.bank);
            m_addr = hcur.addr; m_wdata = hcur.wdata; m_wait = 0;
            hv_active = 0;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic push(input bit we, input int bank, input int addr, input int wdata);
        hreq_t r;
        r.we = we; r.bank = BW'(bank); r.addr = AW'(addr); r.wdata = DW'(wdata);
        hq.push_back(r);
    endtask

    // Run until the host side is quiet, bounded; a timeout counts as a failure.
    task automatic drain();
        int n = 0;
        while ((hv_active || hq.size() > 0 || m_pend || rsp_q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", (n >= 200), 0);
        repeat (3) step();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, host_req_ready, 1);
        check({tag, "_mem_ce"}, mem_ce, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_rsp_valid"}, host_rsp_valid, 0);
        check({tag, "_rsp_rdata"}, host_rsp_rdata, 0);
        check({tag, "_err"}, err_bad_bank, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        e_force = '0;
        #2;
        reset_checks("rst");
        // Preload the address window used by all stimulus, while in reset.
        for (int k = 0; k < NB; k++)
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                pl_we = 1; pl_bank = k; pl_addr = addr_at(i);
                pl_data = (k == 2 && i == 8) ? 8'h3C : DW'($urandom);
                refmem[k][pl_addr] = pl_data;
            end
        @(negedge clk);
        pl_we = 0;
        rst_n = 1;

        // Idle engine: write then read back bank 1.
        p_eng = 0; e_force = '0;
        push(1, 1, 'h05, 'hA5);
        push(0, 1, 'h05, 0);
        drain();

        // Engine holds bank 0: host write waits for the starvation limit.
        e_force = 3'b001; p_wr = 50;
        push(1, 0, 'h03, 'h5A);
        drain();

        // Engine on all banks, reads only: host read of bank 2 top word.
        e_force = 3'b111; p_wr = 0;
        push(0, 2, 'h3FF, 0);
        drain();
        e_force = '0; p_wr = 50;

        // Out-of-range bank: no SRAM access, sticky error, zero read data.
        push(0, 3, 'h01, 0);
        push(1, 3, 'h02, 'h77);
        drain();

        // Reset while a host read is between win and response.
        push(0, 1, 'h05, 0);
        step();
        step();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        reset_checks("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (6) step();

        // Randomized traffic on both sides.
        p_eng = 50;
        for (int i = 0; i < 3000; i++) begin
            if (hq.size() == 0 && $urandom_range(0, 2) == 0)
                push($urandom_range(0, 1), $urandom_range(0, 3), int'(raddr()), int'($urandom_range(0, 255)));
            step();
        end
        p_eng = 0;
        drain();

        for (int k = 0; k < NB; k++)
            for (int i = 0; i < 9; i++)
                check("bank_content", sram[k][addr_at(i)], refmem[k][addr_at(i)]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
